// File: rtl/autenticacao_requisitante.sv
// Sequential front end for the combinational authentication comparator.
// Shifts a credential in serially, presents it to the comparator for one
// strobe cycle, registers the resulting level as a held grant, and counts
// consecutive failures with a timed lockout.
// Optional build macro AUTH_TIMEOUT_EN: treats inactivity during entry as a
// failed attempt.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for the first bit; a bare submit counts as a failure
// S_SHIFT   | collecting credential bits (up to CODE_W, extras dropped)
// S_PRESENT | code_out stable, code_strobe high, aut_in captured
// S_CHECK   | captured level decides grant or failure
// S_GRANTED | grant held until abort (logout)
// S_LOCKED  | all inputs ignored for LOCK_CYCLES cycles
module autenticacao_requisitante #(
  parameter int CODE_W         = 6,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              submit,
  input  logic              abort,
  input  logic [2:0]        aut_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_strobe,
  output logic [2:0]        grant,
  output logic              granted,
  output logic              fail_pulse,
  output logic [3:0]        fail_cnt,
  output logic              locked,
  output logic              busy
);

  localparam int BCW = $clog2(CODE_W + 1);
  localparam int LCW = $clog2(LOCK_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_PRESENT, S_CHECK, S_GRANTED, S_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]        result_q, result_d;
  logic [2:0]        grant_q, grant_d;
  logic [3:0]        fail_cnt_q, fail_cnt_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              fail_pulse_q, fail_pulse_d;
  logic              do_fail;
  logic              timeout_hit;
  logic [3:0]        fail_inc;

  // Failure count after one more failed attempt, saturating at MAX_TRIES.
  assign fail_inc = (fail_cnt_q >= 4'(MAX_TRIES)) ? 4'(MAX_TRIES) : fail_cnt_q + 4'd1;

`ifdef AUTH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          bit_accept;

  assign bit_accept  = bit_valid && (bit_cnt_q < BCW'(CODE_W)) && !abort && !submit;
  assign timeout_hit = (state_q == S_SHIFT) && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: runs only in SHIFT, restarts on every accepted bit.
  always_comb begin
    idle_cnt_d = '0;
    if (state_q == S_SHIFT && !bit_accept) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  // Inactivity counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and datapath updates; every failure route funnels into do_fail.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    bit_cnt_d    = bit_cnt_q;
    result_d     = result_q;
    grant_d      = grant_q;
    fail_cnt_d   = fail_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    fail_pulse_d = 1'b0;
    do_fail      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bit_valid) begin
          code_d    = {code_q[CODE_W-2:0], bit_in};
          bit_cnt_d = BCW'(1);
          state_d   = S_SHIFT;
        end else if (submit) begin
          do_fail = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          code_d    = '0;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (submit) begin
          if (bit_cnt_q == BCW'(CODE_W)) state_d = S_PRESENT;
          else                           do_fail = 1'b1;
        end else if (bit_valid && bit_cnt_q < BCW'(CODE_W)) begin
          code_d    = {code_q[CODE_W-2:0], bit_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (timeout_hit) begin
          do_fail = 1'b1;
        end
      end
      S_PRESENT: begin
        result_d = aut_in;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        code_d    = '0;
        bit_cnt_d = '0;
        if (result_q != 3'b000) begin
          grant_d    = result_q;
          fail_cnt_d = 4'd0;
          state_d    = S_GRANTED;
        end else begin
          do_fail = 1'b1;
        end
      end
      S_GRANTED: begin
        if (abort) begin
          grant_d = 3'b000;
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          lock_cnt_d = '0;
          fail_cnt_d = 4'd0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_fail) begin
      fail_pulse_d = 1'b1;
      code_d       = '0;
      bit_cnt_d    = '0;
      fail_cnt_d   = fail_inc;
      lock_cnt_d   = '0;
      state_d      = (fail_inc == 4'(MAX_TRIES)) ? S_LOCKED : S_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      bit_cnt_q    <= '0;
      result_q     <= 3'b000;
      grant_q      <= 3'b000;
      fail_cnt_q   <= 4'd0;
      lock_cnt_q   <= '0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      bit_cnt_q    <= bit_cnt_d;
      result_q     <= result_d;
      grant_q      <= grant_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  assign code_out    = code_q;
  assign code_strobe = (state_q == S_PRESENT);
  assign grant       = grant_q;
  assign granted     = (state_q == S_GRANTED);
  assign fail_pulse  = fail_pulse_q;
  assign fail_cnt    = fail_cnt_q;
  assign locked      = (state_q == S_LOCKED);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_autenticacao_requisitante.sv
// Bench for autenticacao_requisitante: directed vector table, hand-written
// lockout / reset / inactivity sequences, and randomized attempts checked
// against an attempt-level model.
module tb_autenticacao_requisitante;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, submit = 1'b0, abort = 1'b0;
  logic [2:0] aut_in;
  logic [5:0] code_out;
  logic       code_strobe, granted, fail_pulse, locked, busy;
  logic [2:0] grant;
  logic [3:0] fail_cnt;

  logic [2:0] auth_tab [64];
  assign aut_in = auth_tab[code_out];

  autenticacao_requisitante dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .submit(submit), .abort(abort), .aut_in(aut_in), .code_out(code_out),
    .code_strobe(code_strobe), .grant(grant), .granted(granted),
    .fail_pulse(fail_pulse), .fail_cnt(fail_cnt), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic       bv, b, sub, ab;
    logic [17:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [17:0] pk(input logic [5:0] c, input logic st, input logic gd,
                                     input logic [2:0] gr, input logic fp, input logic [3:0] fc,
                                     input logic lk, input logic by);
    return {c, st, gd, gr, fp, fc, lk, by};
  endfunction

  function automatic logic [17:0] outs();
    return {code_out, code_strobe, granted, grant, fail_pulse, fail_cnt, locked, busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic bv, input logic b, input logic sub, input logic ab,
                   input logic [5:0] c, input logic st, input logic gd, input logic [2:0] gr,
                   input logic fp, input logic [3:0] fc, input logic lk, input logic by);
    vec_t r;
    r.bv = bv; r.b = b; r.sub = sub; r.ab = ab;
    r.exp = pk(c, st, gd, gr, fp, fc, lk, by);
    vecs.push_back(r);
  endtask

  // One clock with the given inputs; returns #1 after the rising edge.
  task automatic cyc(input logic bv, input logic b, input logic sub, input logic ab);
    bit_valid = bv; bit_in = b; submit = sub; abort = ab;
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b0; submit = 1'b0; abort = 1'b0;
  endtask

  task automatic do_reset();
    bit_valid = 1'b0; bit_in = 1'b0; submit = 1'b0; abort = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // A complete all-zero entry that the comparator rejects; k is the expected new count.
  task automatic fail_entry(input int k);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fe_strobe", code_strobe, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fe_result", {fail_pulse, fail_cnt, locked}, {1'b1, 4'(k), (k == 3)});
  endtask

  int          cnt;
  int          n, ending, acc, m_fail;
  logic        bb, withbit;
  logic [5:0]  mcode;
  logic [2:0]  level;
  logic [17:0] expv;

  initial begin
    foreach (auth_tab[i]) auth_tab[i] = 3'b000;
    auth_tab[6'b101100] = 3'b001;
    auth_tab[6'b111111] = 3'b110;

    do_reset();
    chk("reset_state", outs(), 0);

    // Directed vectors: valid grant, short submit, overfill, abort priority, bare submit.
    v(1,1,0,0, 6'b000001,0,0,3'b000,0,0,0,1);
    v(1,0,0,0, 6'b000010,0,0,3'b000,0,0,0,1);
    v(1,1,0,0, 6'b000101,0,0,3'b000,0,0,0,1);
    v(1,1,0,0, 6'b001011,0,0,3'b000,0,0,0,1);
    v(1,0,0,0, 6'b010110,0,0,3'b000,0,0,0,1);
    v(1,0,0,0, 6'b101100,0,0,3'b000,0,0,0,1);
    v(0,0,1,0, 6'b101100,1,0,3'b000,0,0,0,1);
    v(0,0,0,0, 6'b101100,0,0,3'b000,0,0,0,1);
    v(0,0,0,0, 6'b000000,0,1,3'b001,0,0,0,1);
    v(1,1,1,0, 6'b000000,0,1,3'b001,0,0,0,1);
    v(0,0,0,1, 6'b000000,0,0,3'b000,0,0,0,0);
    v(1,1,0,0, 6'b000001,0,0,3'b000,0,0,0,1);
    v(1,1,0,0, 6'b000011,0,0,3'b000,0,0,0,1);
    v(1,0,0,0, 6'b000110,0,0,3'b000,0,0,0,1);
    v(1,1,0,0, 6'b001101,0,0,3'b000,0,0,0,1);
    v(0,0,1,0, 6'b000000,0,0,3'b000,1,1,0,0);
    v(0,0,0,0, 6'b000000,0,0,3'b000,0,1,0,0);
    v(1,1,0,0, 6'b000001,0,0,3'b000,0,1,0,1);
    v(1,1,0,0, 6'b000011,0,0,3'b000,0,1,0,1);
    v(1,1,0,0, 6'b000111,0,0,3'b000,0,1,0,1);
    v(1,1,0,0, 6'b001111,0,0,3'b000,0,1,0,1);
    v(1,1,0,0, 6'b011111,0,0,3'b000,0,1,0,1);
    v(1,1,0,0, 6'b111111,0,0,3'b000,0,1,0,1);
    v(1,0,0,0, 6'b111111,0,0,3'b000,0,1,0,1);
    v(1,0,0,0, 6'b111111,0,0,3'b000,0,1,0,1);
    v(1,0,1,0, 6'b111111,1,0,3'b000,0,1,0,1);
    v(0,0,0,0, 6'b111111,0,0,3'b000,0,1,0,1);
    v(0,0,0,0, 6'b000000,0,1,3'b110,0,0,0,1);
    v(0,0,0,1, 6'b000000,0,0,3'b000,0,0,0,0);
    v(1,1,0,0, 6'b000001,0,0,3'b000,0,0,0,1);
    v(1,1,1,1, 6'b000000,0,0,3'b000,0,0,0,0);
    v(0,0,1,0, 6'b000000,0,0,3'b000,1,1,0,0);
    v(0,0,0,1, 6'b000000,0,0,3'b000,0,1,0,0);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].bv, vecs[i].b, vecs[i].sub, vecs[i].ab);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Lockout: three rejected entries, bit_valid hammered during the lock.
    do_reset();
    fail_entry(1);
    fail_entry(2);
    fail_entry(3);
    cnt = 0;
    while (locked === 1'b1 && cnt < 100) begin
      cnt++;
      chk("lock_code_hold", code_out, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("lock_len", cnt, 16);
    chk("lock_exit", {busy, fail_cnt, code_out}, 0);

    // Asynchronous reset mid-entry.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("rst_mid_shift", outs(), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_shift_restart", outs(), pk(6'b000001,0,0,3'b000,0,0,0,1));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset at lock_cnt=5.
    fail_entry(1);
    fail_entry(2);
    fail_entry(3);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_locked", locked, 1);
    #3 rst_n = 1'b0;
    #1 chk("rst_in_lock", outs(), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_lock_idle", outs(), 0);

    // Inactivity during entry.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef AUTH_TIMEOUT_EN
    repeat (63) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_before", {busy, fail_pulse}, 2'b10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_fire", outs(), pk(6'b000000,0,0,3'b000,1,1,0,0));
`else
    repeat (200) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_timeout", {busy, fail_pulse, code_out}, {1'b1, 1'b0, 6'b000010});
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized attempts against an attempt-level model.
    do_reset();
    foreach (auth_tab[i]) auth_tab[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    m_fail = 0;
    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(0, 8));
      ending = int'($urandom_range(0, 9));
      mcode = 6'b000000;
      acc = 0;
      for (int i = 0; i < n; i++) begin
        bb = 1'($urandom_range(0, 1));
        if (acc < 6) begin
          mcode = {mcode[4:0], bb};
          acc++;
        end
        cyc(1'b1, bb, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (n > 0) chk("rnd_code", code_out, mcode);
      if (ending < 2) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rnd_abort", outs(), pk(6'b000000,0,0,3'b000,0,4'(m_fail),0,0));
      end else begin
        withbit = (ending == 2) && (n > 0);
        cyc(withbit, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        level = 3'b000;
        if (n >= 6) begin
          chk("rnd_strobe", {code_strobe, code_out}, {1'b1, mcode});
          cyc(1'b0, 1'b0, 1'b0, 1'b0);
          cyc(1'b0, 1'b0, 1'b0, 1'b0);
          level = auth_tab[mcode];
        end
        if (level != 3'b000) begin
          m_fail = 0;
          expv = pk(6'b000000,0,1,level,0,0,0,1);
        end else begin
          m_fail++;
          expv = pk(6'b000000,0,0,3'b000,1,4'(m_fail),(m_fail == 3),(m_fail == 3));
        end
        chk("rnd_outcome", outs(), expv);
        if (level != 3'b000) begin
          cyc(1'b0, 1'b0, 1'b0, 1'b1);
          chk("rnd_logout", outs(), 0);
        end
        if (m_fail == 3) begin
          cnt = 0;
          while (locked === 1'b1 && cnt < 100) begin
            cnt++;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          end
          chk("rnd_lock_len", cnt, 16);
          m_fail = 0;
          chk("rnd_lock_exit", outs(), 0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
